// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control FSM for the 16-bit RISC datapath
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       imm7_nz,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       tgt_write,
  output logic       addr_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic       mem_err,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_ADDR = 4'd4,
    S_MEM_RD    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_WB_ALU    = 4'd7,
    S_WB_MEM    = 4'd8,
    S_WB_LUI    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JALR      = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  // Value of the wait counter on the last cycle a request may go unanswered.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q;
  logic       mem_err_q;
  logic       in_mem;
  logic       waiting;
  logic       timeout;

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign waiting = in_mem && !mem_ready;
  // A response arriving in the final allowed cycle wins over the timeout.
  assign timeout = (MEM_TIMEOUT > 0) && waiting && (wait_cnt_q == TIMEOUT_LAST);

  // Next-state selection from current state, opcode and memory handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          3'b000, 3'b010:         state_d = S_EXEC_R;
          3'b001, 3'b100, 3'b101: state_d = S_EXEC_ADDR;
          3'b011:                 state_d = S_WB_LUI;
          3'b110:                 state_d = S_BRANCH;
          default:                state_d = imm7_nz ? S_HALT : S_JALR;
        endcase
      end
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_ADDR: begin
        case (opcode)
          3'b101:  state_d = S_MEM_RD;
          3'b100:  state_d = S_MEM_WR;
          default: state_d = S_WB_ALU;
        endcase
      end
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_WB_MEM;
        else if (timeout) state_d = S_HALT;
      end
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_HALT;
      end
      S_WB_ALU, S_WB_MEM, S_WB_LUI, S_BRANCH, S_JALR: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RESET;
    endcase
  end

  // State, wait counter (cleared on every state change) and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt_q <= 8'd0;
      end else if (waiting && (wait_cnt_q != 8'hFF)) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (timeout) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  // Datapath controls decoded from state; fetch/branch strobes qualified by inputs.
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    tgt_write = 1'b0;
    addr_sel  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 2'b00;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        tgt_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = (opcode == 3'b010) ? 2'b01 : 2'b00;
      end
      S_EXEC_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = 1'b1;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        // Register-register ops write rC; ADDI writes rA.
        reg_dst   = (opcode == 3'b000) || (opcode == 3'b010);
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
      end
      S_WB_LUI: begin
        alu_src_b = 2'b11;
        alu_op    = 2'b11;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        pc_write  = alu_zero;
        pc_src    = alu_zero ? 2'b01 : 2'b00;
      end
      S_JALR: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_src    = 2'b10;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_err   = mem_err_q;
  assign state_dbg = state_q;

endmodule
